// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes, default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // 50 MHz system clock: 100 us inhibit, 15 ms device watchdog.
    localparam int PS2_INHIBIT_CYCLES = 5000;
    localparam int PS2_TIMEOUT_CYCLES = 750000;
    localparam int PS2_SYNC_STAGES    = 3;
    localparam int PS2_MAX_RETRIES    = 2;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the asynchronous PS/2 clock/data lines and flags device falling edges.
module ps2_line_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [STAGES-1:0] data_sync_q, data_sync_d;
    logic              clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[STAGES-1];
    end

    // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_s    = clk_sync_q[STAGES-1];
    assign data_s   = data_sync_q[STAGES-1];
    assign clk_fall = clk_prev_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, parity, stop, ack).
// Define PS2_HOST_TX_RETRY_EN to re-send a failed frame up to two more times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = PS2_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

    ps2_state_e state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       par_q, par_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [WW-1:0] wd_q, wd_d;
    logic       ok_q, ok_d;
    logic       clk_oe_q, clk_oe_d;
    logic       data_oe_q, data_oe_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0] retry_q, retry_d;
`endif

    logic clk_s, data_s, clk_fall;
    logic watching, timeout, fail;

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fall (clk_fall)
    );

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        wd_d      = wd_q;
        ok_d      = ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        watching = state_q inside {RELEASE, DATA, PARITY, STOP, ACK, WAIT_IDLE};
        if (watching) wd_d = clk_fall ? '0 : wd_q + 1'b1;

        case (state_q)
            IDLE: if (tx_valid) begin
                byte_d    = tx_data;
                par_d     = ps2_odd_parity(tx_data);
                inh_cnt_d = '0;
                ok_d      = 1'b0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                retry_d   = '0;
`endif
            end
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                // Start bit goes low one cycle before the clock is released.
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    wd_d     = '0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: if (clk_fall) begin
                data_oe_d = ~byte_q[0];
                bit_cnt_d = 3'd1;
                state_d   = DATA;
            end
            DATA: if (clk_fall) begin
                data_oe_d = ~byte_q[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (clk_fall) begin
                data_oe_d = ~par_q;
                state_d   = STOP;
            end
            STOP: if (clk_fall) begin
                data_oe_d = 1'b0;
                state_d   = ACK;
            end
            ACK: if (clk_fall) begin
                ok_d    = ~data_s;
                fail    = data_s;
                state_d = WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_s && data_s) begin
                done_d  = ok_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        timeout = watching && !clk_fall && (wd_q == WW'(TIMEOUT_CYCLES - 1)) &&
                  !(state_q == WAIT_IDLE && clk_s && data_s);
        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
            // A missing ack already reported its error; only an acked frame stuck here errs.
            if (state_q != WAIT_IDLE) fail = 1'b1;
            else                      err_d = ok_q;
        end

        if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_q < 2'(PS2_MAX_RETRIES)) begin
                retry_d   = retry_q + 1'b1;
                inh_cnt_d = '0;
                ok_d      = 1'b0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = INHIBIT;
            end else begin
                err_d = 1'b1;
            end
`else
            err_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            wd_q      <= '0;
            ok_q      <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            wd_q      <= wd_d;
            ok_q      <= ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = (state_q == IDLE);
    assign tx_busy     = (state_q != IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and checks them.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TO  = 600;
    localparam int SYN = 3;
    localparam int H   = 25;
    localparam int LIM = 5000;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       tx_ready, tx_busy, tx_done, tx_err;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYN)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    int vec_cnt = 0, miss_cnt = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;

    always @(posedge clk) if (clrn && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;

    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ref_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // Device side of one frame: observe inhibit, then generate nfalls clock pulses,
    // sampling the line at each rising edge and optionally driving the ack.
    task automatic dev_frame(input bit do_ack, input int nfalls, output logic [9:0] bits);
        int n;
        logic last_doe;
        bits = '0;
        @(negedge clk);
        n = 0;
        while (!ps2_clk_oe && n < LIM) begin @(negedge clk); n++; end
        chk("inhibit_seen", 32'(ps2_clk_oe), 32'd1);
        n = 0;
        last_doe = 1'b0;
        while (ps2_clk_oe && n < LIM) begin last_doe = ps2_data_oe; @(negedge clk); n++; end
        chk("inhibit_len", 32'(n), 32'(INH));
        chk("start_before_release", 32'(last_doe), 32'd1);
        repeat (4) @(negedge clk);
        chk("start_bit_line", 32'(ps2_data), 32'd0);
        chk("busy_not_ready", 32'({tx_ready, tx_busy}), 32'b01);
        for (int i = 0; i < nfalls; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i < 10) bits[i] = ps2_data;
            dev_clk_low = 1'b0;
            if (i == 9) dev_data_low = do_ack;
            if (i < nfalls - 1 || do_ack) repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 4 * LIM) begin @(negedge clk); n++; end
        chk("back_to_idle", 32'(tx_ready), 32'd1);
    endtask

    task automatic full_frame(input logic [7:0] b, input bit ack);
        int d0, e0;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        dev_frame(ack, 11, bits);
        wait_idle();
        repeat (3) @(negedge clk);
        chk($sformatf("data_%02h", b), 32'(bits[7:0]), 32'(b));
        chk($sformatf("parity_%02h", b), 32'(bits[8]), 32'(ref_par(b)));
        chk("stop_bit", 32'(bits[9]), 32'd1);
        chk("done_pulses", 32'(done_cnt - d0), 32'(ack));
        chk("err_pulses", 32'(err_cnt - e0), 32'(!ack));
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, e0, a0, n;
        logic [9:0] b1, b2, bx;

        repeat (3) @(negedge clk);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rst_ready_busy", 32'({tx_ready, tx_busy}), 32'b10);
        chk("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
        @(posedge clk); #1 clrn = 1'b1;

        full_frame(PS2_CMD_SET_LED, 1'b1);
        full_frame(8'h00, 1'b1);
        full_frame(8'h01, 1'b1);
        full_frame(8'hFF, 1'b1);
        full_frame(8'h3C, 1'b0);
        for (int k = 0; k < 6; k++) full_frame(8'($urandom), $urandom_range(0, 3) != 0);

        // Device never clocks after release.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h55);
        n = 0;
        @(negedge clk);
        while (ps2_clk_oe && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_err && n < 4 * TO) begin @(negedge clk); n++; end
        chk("timeout_window", 32'(n >= TO && n <= TO + 2), 32'd1);
        chk("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("timeout_idle", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("timeout_err", 32'(err_cnt - e0), 32'd1);
        chk("timeout_done", 32'(done_cnt - d0), 32'd0);

        // Reset mid-frame after bit 3 (0xA5 bit 3 is 0, so data is being pulled).
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        dev_frame(1'b1, 4, bx);
        chk("bit3_driven", 32'(ps2_data_oe), 32'd1);
        #2 clrn = 1'b0;
        #1 chk("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        @(posedge clk); #1 clrn = 1'b1;
        chk("rst_mid_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        full_frame(PS2_CMD_RESET, 1'b1);

        // tx_valid held high across a frame while tx_data changes.
        wait_idle();
        a0 = acc_cnt;
        d0 = done_cnt;
        fork
            begin
                int m;
                @(posedge clk); #1;
                tx_data  = 8'hC3;
                tx_valid = 1'b1;
                m = 0;
                while (acc_cnt == a0 && m < LIM) begin @(posedge clk); #1; m++; end
                tx_data = 8'h5A;
                m = 0;
                while (acc_cnt == a0 + 1 && m < 4 * LIM) begin @(posedge clk); #1; m++; end
                tx_valid = 1'b0;
            end
            begin
                dev_frame(1'b1, 11, b1);
                dev_frame(1'b1, 11, b2);
            end
        join
        wait_idle();
        repeat (3) @(negedge clk);
        chk("held_first", 32'(b1[7:0]), 32'hC3);
        chk("held_second", 32'(b2[7:0]), 32'h5A);
        chk("held_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("held_done", 32'(done_cnt - d0), 32'd2);

        chk("done_err_overlap", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
